// File: rtl/dzcpu_useq.sv
// dzcpu micro-sequencer: mOp fetch, flow lookup, micro-PC stepping and flow-control decode.
// Optional flow-length watchdog is built when DZCPU_USEQ_WDOG_EN is defined.
module dzcpu_useq #(
   parameter int UOP_W        = 12,
   parameter int MAX_FLOW_LEN = 32
) (
   input  logic             iClock,
   input  logic             iReset,
   input  logic             iMopValid,
   input  logic [7:0]       iMemData,
   output logic             oFetchReq,
   output logic [7:0]       oLutMop,
   input  logic [7:0]       iFlowIdx,
   output logic [7:0]       oCbLutMop,
   input  logic [7:0]       iCbFlowIdx,
   output logic [7:0]       oUopAddr,
   input  logic [UOP_W-1:0] iUop,
   output logic             oUopValid,
   output logic [UOP_W-4:0] oUopOp,
   input  logic             iFlagZ,
   input  logic             iStall,
   output logic             oPcInc,
   output logic             oEof,
   output logic             oError
);

   typedef enum logic [1:0] {FETCH, LOOKUP, EXEC, CBLOOKUP} state_t;

   localparam logic [2:0] F_OP        = 3'd0;
   localparam logic [2:0] F_INC       = 3'd1;
   localparam logic [2:0] F_EOF       = 3'd2;
   localparam logic [2:0] F_INC_EOF   = 3'd3;
   localparam logic [2:0] F_INC_EOF_Z = 3'd4;
   localparam logic [2:0] F_JCB       = 3'd5;

   // The watchdog counter is 6 bits wide, so the limit must fit in it.
   if (MAX_FLOW_LEN < 1 || MAX_FLOW_LEN > 63) begin : g_bad_max_flow_len
      $error("MAX_FLOW_LEN must be in 1..63");
   end

   state_t     state_q, state_d;
   logic [7:0] upc_q, upc_d;
   logic [7:0] lut_mop_q, lut_mop_d;
   logic [7:0] cb_mop_q, cb_mop_d;
   logic [2:0] flow;
   logic       pc_inc, eof, uop_valid, wdog_trip;

   assign flow = iUop[UOP_W-1:UOP_W-3];

   // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      upc_d     = upc_q;
      lut_mop_d = lut_mop_q;
      cb_mop_d  = cb_mop_q;
      pc_inc    = 1'b0;
      eof       = 1'b0;
      uop_valid = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (iMopValid) begin
               lut_mop_d = iMemData;
               state_d   = LOOKUP;
            end
         end
         LOOKUP: begin
            upc_d   = iFlowIdx;
            state_d = EXEC;
         end
         CBLOOKUP: begin
            upc_d   = iCbFlowIdx;
            state_d = EXEC;
         end
         EXEC: begin
            if (!iStall) begin
               uop_valid = 1'b1;
               unique case (flow)
                  F_INC: begin
                     pc_inc = 1'b1;
                     upc_d  = upc_q + 8'd1;
                  end
                  F_EOF: begin
                     eof     = 1'b1;
                     state_d = FETCH;
                  end
                  F_INC_EOF: begin
                     pc_inc  = 1'b1;
                     eof     = 1'b1;
                     state_d = FETCH;
                  end
                  F_INC_EOF_Z: begin
                     pc_inc = 1'b1;
                     if (iFlagZ) begin
                        eof     = 1'b1;
                        state_d = FETCH;
                     end else begin
                        upc_d = upc_q + 8'd1;
                     end
                  end
                  F_JCB: begin
                     // The flow guarantees the CB sub-opcode is on the bus here.
                     pc_inc   = 1'b1;
                     cb_mop_d = iMemData;
                     state_d  = CBLOOKUP;
                  end
                  default: upc_d = upc_q + 8'd1;
               endcase
            end
         end
         default: state_d = FETCH;
      endcase
      if (wdog_trip) state_d = FETCH;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state_q   <= FETCH;
         upc_q     <= 8'd0;
         lut_mop_q <= 8'd0;
         cb_mop_q  <= 8'd0;
      end else begin
         state_q   <= state_d;
         upc_q     <= upc_d;
         lut_mop_q <= lut_mop_d;
         cb_mop_q  <= cb_mop_d;
      end
   end

`ifdef DZCPU_USEQ_WDOG_EN
   logic [5:0] wdog_cnt_q, wdog_cnt_d, wdog_cnt_inc;
   logic       error_q;

   assign wdog_cnt_inc = wdog_cnt_q + 6'd1;

   // Trip only when the flow would otherwise keep executing; eof and jcb exit on their own.
   always_comb begin
      wdog_cnt_d = wdog_cnt_q;
      wdog_trip  = 1'b0;
      if (state_q == LOOKUP || state_q == CBLOOKUP) begin
         wdog_cnt_d = 6'd0;
      end else if (state_q == EXEC && !iStall) begin
         wdog_cnt_d = wdog_cnt_inc;
         wdog_trip  = (int'(wdog_cnt_inc) >= MAX_FLOW_LEN) && !eof && (flow != F_JCB);
      end
   end

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         wdog_cnt_q <= 6'd0;
         error_q    <= 1'b0;
      end else begin
         wdog_cnt_q <= wdog_cnt_d;
         error_q    <= error_q | wdog_trip;
      end
   end

   assign oError = error_q;
`else
   assign wdog_trip = 1'b0;
   assign oError    = 1'b0;
`endif

   assign oFetchReq = (state_q == FETCH);
   assign oLutMop   = lut_mop_q;
   assign oCbLutMop = cb_mop_q;
   assign oUopAddr  = upc_q;
   assign oUopValid = uop_valid;
   assign oUopOp    = iUop[UOP_W-4:0];
   assign oPcInc    = pc_inc;
   assign oEof      = eof;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Directed bench for dzcpu_useq: bench-owned ROM and lookup tables, inputs driven at the
// falling edge and outputs checked 1 ns later.
module tb_dzcpu_useq;

   localparam int UOP_W = 12;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             mop_valid;
   logic [7:0]       mem_data;
   logic             fetch_req;
   logic [7:0]       lut_mop, flow_idx, cb_lut_mop, cb_flow_idx, uop_addr;
   logic [UOP_W-1:0] uop;
   logic             uop_valid;
   logic [UOP_W-4:0] uop_op;
   logic             flag_z, stall, pc_inc, eof, error;

   int checks = 0;
   int errors = 0;

   logic [UOP_W-1:0] rom [256];

   dzcpu_useq #(.UOP_W(UOP_W), .MAX_FLOW_LEN(32)) dut (
      .iClock(clk), .iReset(rst_n), .iMopValid(mop_valid), .iMemData(mem_data),
      .oFetchReq(fetch_req), .oLutMop(lut_mop), .iFlowIdx(flow_idx),
      .oCbLutMop(cb_lut_mop), .iCbFlowIdx(cb_flow_idx), .oUopAddr(uop_addr),
      .iUop(uop), .oUopValid(uop_valid), .oUopOp(uop_op), .iFlagZ(flag_z),
      .iStall(stall), .oPcInc(pc_inc), .oEof(eof), .oError(error)
   );

   always #5 clk = ~clk;

   assign uop = rom[uop_addr];

   always_comb begin
      case (lut_mop)
         8'h31:   flow_idx = 8'd1;
         8'hCB:   flow_idx = 8'd13;
         8'h20:   flow_idx = 8'd17;
         8'h40:   flow_idx = 8'd255;
         default: flow_idx = 8'd0;
      endcase
   end

   assign cb_flow_idx = (cb_lut_mop == 8'h7C) ? 8'd16 : 8'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks one EXEC/CBLOOKUP cycle, then advances to the next falling edge.
   task automatic step(input string tag, input logic [7:0] addr, input logic valid,
                       input logic pc, input logic e);
      #1;
      chk({tag, ".addr"}, 32'(uop_addr), 32'(addr));
      chk({tag, ".valid"}, 32'(uop_valid), 32'(valid));
      chk({tag, ".pcinc"}, 32'(pc_inc), 32'(pc));
      chk({tag, ".eof"}, 32'(eof), 32'(e));
      if (valid) chk({tag, ".op"}, 32'(uop_op), {24'd0, addr});
      @(negedge clk);
   endtask

   // Presents an mOp in FETCH and checks the LOOKUP cycle; returns at the first EXEC cycle.
   task automatic fetch(input string tag, input logic [7:0] mop);
      mop_valid = 1'b1;
      mem_data  = mop;
      #1 chk({tag, ".fetchreq"}, 32'(fetch_req), 32'd1);
      @(negedge clk);
      mop_valid = 1'b0;
      #1;
      chk({tag, ".lutmop"}, 32'(lut_mop), 32'(mop));
      chk({tag, ".lookup_fetchreq"}, 32'(fetch_req), 32'd0);
      chk({tag, ".lookup_valid"}, 32'(uop_valid), 32'd0);
      @(negedge clk);
   endtask

   task automatic expect_fetch(input string tag);
      #1;
      chk({tag, ".fetchreq"}, 32'(fetch_req), 32'd1);
      chk({tag, ".valid"}, 32'(uop_valid), 32'd0);
      chk({tag, ".pcinc"}, 32'(pc_inc), 32'd0);
      chk({tag, ".eof"}, 32'(eof), 32'd0);
   endtask

   // Flow field in [11:9]; operation field carries the ROM address so the op pass-through is visible.
   function automatic logic [UOP_W-1:0] mk(input logic [2:0] f, input logic [7:0] a);
      return {f, 1'b0, a};
   endfunction

   initial begin
      for (int a = 0; a < 256; a++) rom[a] = mk(3'd0, 8'(a));
      rom[0]  = mk(3'd3, 8'd0);
      rom[1]  = mk(3'd1, 8'd1);
      rom[2]  = mk(3'd1, 8'd2);
      rom[4]  = mk(3'd3, 8'd4);
      rom[13] = mk(3'd1, 8'd13);
      rom[15] = mk(3'd5, 8'd15);
      rom[16] = mk(3'd2, 8'd16);
      rom[19] = mk(3'd4, 8'd19);
      rom[22] = mk(3'd2, 8'd22);

      rst_n = 1'b0; mop_valid = 1'b0; mem_data = 8'h00; flag_z = 1'b0; stall = 1'b0;
      #1;
      chk("reset.fetchreq", 32'(fetch_req), 32'd1);
      chk("reset.addr", 32'(uop_addr), 32'd0);
      chk("reset.lutmop", 32'(lut_mop), 32'd0);
      chk("reset.cblutmop", 32'(cb_lut_mop), 32'd0);
      chk("reset.error", 32'(error), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic flow: inc, inc, op, inc_eof
      fetch("basic", 8'h31);
      step("basic1", 8'd1, 1'b1, 1'b1, 1'b0);
      step("basic2", 8'd2, 1'b1, 1'b1, 1'b0);
      step("basic3", 8'd3, 1'b1, 1'b0, 1'b0);
      step("basic4", 8'd4, 1'b1, 1'b1, 1'b1);
      expect_fetch("basic_end");

      // Conditional eof taken
      fetch("condz1", 8'h20);
      flag_z = 1'b1;
      step("condz1_17", 8'd17, 1'b1, 1'b0, 1'b0);
      step("condz1_18", 8'd18, 1'b1, 1'b0, 1'b0);
      step("condz1_19", 8'd19, 1'b1, 1'b1, 1'b1);
      expect_fetch("condz1_end");

      // Conditional eof not taken
      fetch("condz0", 8'h20);
      flag_z = 1'b0;
      step("condz0_17", 8'd17, 1'b1, 1'b0, 1'b0);
      step("condz0_18", 8'd18, 1'b1, 1'b0, 1'b0);
      step("condz0_19", 8'd19, 1'b1, 1'b1, 1'b0);
      step("condz0_20", 8'd20, 1'b1, 1'b0, 1'b0);
      step("condz0_21", 8'd21, 1'b1, 1'b0, 1'b0);
      step("condz0_22", 8'd22, 1'b1, 1'b0, 1'b1);
      expect_fetch("condz0_end");

      // CB prefix
      fetch("cb", 8'hCB);
      step("cb13", 8'd13, 1'b1, 1'b1, 1'b0);
      step("cb14", 8'd14, 1'b1, 1'b0, 1'b0);
      mem_data = 8'h7C;
      step("cb15", 8'd15, 1'b1, 1'b1, 1'b0);
      mem_data = 8'h00;
      #1;
      chk("cb.cblutmop", 32'(cb_lut_mop), 32'h7C);
      chk("cb.lookup_valid", 32'(uop_valid), 32'd0);
      chk("cb.lookup_pcinc", 32'(pc_inc), 32'd0);
      @(negedge clk);
      step("cb16", 8'd16, 1'b1, 1'b0, 1'b1);
      expect_fetch("cb_end");

      // Stall for 3 cycles at uPC=2
      fetch("stall", 8'h31);
      step("stall1", 8'd1, 1'b1, 1'b1, 1'b0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) step("stall_hold", 8'd2, 1'b0, 1'b0, 1'b0);
      stall = 1'b0;
      step("stall2", 8'd2, 1'b1, 1'b1, 1'b0);
      step("stall3", 8'd3, 1'b1, 1'b0, 1'b0);
      step("stall4", 8'd4, 1'b1, 1'b1, 1'b1);
      expect_fetch("stall_end");

      // Unmapped opcode runs the generic flow at 0
      fetch("unmapped", 8'hA5);
      step("unmapped0", 8'd0, 1'b1, 1'b1, 1'b1);
      expect_fetch("unmapped_end");

      // uPC wraps 255 -> 0
      fetch("wrap", 8'h40);
      step("wrap255", 8'd255, 1'b1, 1'b0, 1'b0);
      step("wrap0", 8'd0, 1'b1, 1'b1, 1'b1);
      expect_fetch("wrap_end");

      // Asynchronous reset mid-EXEC, checked with no clock edge in between
      fetch("rst", 8'h31);
      step("rst1", 8'd1, 1'b1, 1'b1, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid.fetchreq", 32'(fetch_req), 32'd1);
      chk("rst_mid.valid", 32'(uop_valid), 32'd0);
      chk("rst_mid.pcinc", 32'(pc_inc), 32'd0);
      chk("rst_mid.eof", 32'(eof), 32'd0);
      chk("rst_mid.addr", 32'(uop_addr), 32'd0);
      chk("rst_mid.lutmop", 32'(lut_mop), 32'd0);
      chk("rst_mid.cblutmop", 32'(cb_lut_mop), 32'd0);
      chk("rst_mid.error", 32'(error), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_fetch("rst_release");
      @(negedge clk);
      fetch("post_rst", 8'h31);
      step("post_rst1", 8'd1, 1'b1, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
